// File: rtl/rc4_pkg.sv
// ============================================================================
// rc4_pkg : shared types and constants for the RC4 decrypt pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_I   = 4'd1,
        WAIT_I = 4'd2,
        SAVE_I = 4'd3,
        RD_J   = 4'd4,
        WAIT_J = 4'd5,
        SAVE_J = 4'd6,
        WR_I   = 4'd7,
        WR_J   = 4'd8,
        RD_F   = 4'd9,
        WAIT_F = 4'd10,
        SAVE_F = 4'd11,
        WR_PT  = 4'd12,
        DONE   = 4'd13
    } prga_state_t;

    localparam int    S_SIZE   = 256;
    localparam byte_t ASCII_LO = 8'h61;
    localparam byte_t ASCII_HI = 8'h7A;
    localparam byte_t ASCII_SP = 8'h20;

    // Lower-case letters or space are the only bytes a plausible plaintext may hold.
    function automatic logic is_plain_byte(input byte_t b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_ascii_chk.sv
// ============================================================================
// rc4_ascii_chk : combinational plaintext byte validity check
// Rev 1.0
// ============================================================================
`default_nettype none

module rc4_ascii_chk
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       valid
);

    assign valid = is_plain_byte(data);

endmodule

`default_nettype wire

// File: rtl/rc4_prga_decrypt.sv
// ============================================================================
// rc4_prga_decrypt : RC4 PRGA stage, XORs keystream with ciphertext ROM bytes
// Optional early abort on non-text plaintext: RC4_ASCII_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int RD_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done_flag,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren,
    output logic       key_bad
);

    localparam int                WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
    localparam byte_t             LAST_K    = 8'(MSG_LEN - 1);

    prga_state_t       state;
    prga_state_t       state_nxt;
    byte_t             i;
    byte_t             j;
    byte_t             k;
    byte_t             si;
    byte_t             sj;
    byte_t             f;
    byte_t             ct;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_end;
    logic              pt_ok;
    logic              last_byte;

    assign wait_end  = (wait_cnt == WAIT_LAST);
    assign last_byte = (k == LAST_K);

`ifdef RC4_ASCII_CHECK_EN
    rc4_ascii_chk u_ascii_chk (
        .data  (pt_wrdata),
        .valid (pt_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_bad <= 1'b0;
        end else if ((state == WR_PT) && !pt_ok) begin
            key_bad <= 1'b1;
        end
    end
`else
    assign pt_ok   = 1'b1;
    assign key_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RD_I;
            RD_I:    state_nxt = WAIT_I;
            WAIT_I:  if (wait_end) state_nxt = SAVE_I;
            SAVE_I:  state_nxt = RD_J;
            RD_J:    state_nxt = WAIT_J;
            WAIT_J:  if (wait_end) state_nxt = SAVE_J;
            SAVE_J:  state_nxt = WR_I;
            WR_I:    state_nxt = WR_J;
            WR_J:    state_nxt = RD_F;
            RD_F:    state_nxt = WAIT_F;
            WAIT_F:  if (wait_end) state_nxt = SAVE_F;
            SAVE_F:  state_nxt = WR_PT;
            WR_PT:   state_nxt = (last_byte || !pt_ok) ? DONE : RD_I;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are held through WAIT and SAVE so the read pipeline keeps
    // presenting the requested word until it is captured.
    always_comb begin
        s_addr    = 8'h00;
        s_wrdata  = 8'h00;
        s_wren    = 1'b0;
        ct_addr   = 8'h00;
        pt_addr   = 8'h00;
        pt_wrdata = 8'h00;
        pt_wren   = 1'b0;
        case (state)
            RD_I, WAIT_I, SAVE_I: s_addr = i;
            RD_J, WAIT_J, SAVE_J: s_addr = j;
            WR_I: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
            end
            WR_J: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            RD_F, WAIT_F, SAVE_F: begin
                s_addr  = si + sj;
                ct_addr = k;
            end
            WR_PT: begin
                pt_addr   = k;
                pt_wrdata = f ^ ct;
                pt_wren   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i         <= 8'h00;
            j         <= 8'h00;
            k         <= 8'h00;
            si        <= 8'h00;
            sj        <= 8'h00;
            f         <= 8'h00;
            ct        <= 8'h00;
            wait_cnt  <= '0;
            done_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= 8'h01;
                        j <= 8'h00;
                        k <= 8'h00;
                    end
                end
                WAIT_I, WAIT_J, WAIT_F: begin
                    wait_cnt <= wait_end ? '0 : wait_cnt + 1'b1;
                end
                SAVE_I: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                SAVE_J: sj <= s_rddata;
                SAVE_F: begin
                    f  <= s_rddata;
                    ct <= ct_rddata;
                end
                WR_PT: begin
                    if (!last_byte && pt_ok) begin
                        k <= k + 8'h01;
                        i <= i + 8'h01;
                    end
                end
                default: ;
            endcase
            done_flag <= done_flag | (state == DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
// ============================================================================
// tb_rc4_prga_decrypt : directed self-checking bench for rc4_prga_decrypt
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rc4_prga_decrypt;
    import rc4_pkg::*;

    localparam int MSG_LEN = 9;
    localparam int RD_LAT  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done_flag;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;
    logic       key_bad;

    always #5 clk = ~clk;

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done_flag (done_flag),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren),
        .key_bad   (key_bad)
    );

    byte_t s_mem [256];
    byte_t s_init [256];
    byte_t ct_mem [256];
    byte_t pt_mem [256];
    byte_t exp_pt [256];
    byte_t s_pipe0, s_pipe1, ct_pipe0, ct_pipe1;
    byte_t snap1, snap2, snap3;
    byte_t plain_txt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    byte_t key_ct [9]    = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic  load_req = 1'b0;
    int    pt_cnt = 0;
    int    wr_cnt = 0;
    int    checks = 0;
    int    errors = 0;

    // Two-stage registered read path gives the RD_LAT=2 memories.
    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_pipe0  <= s_mem[s_addr];
        s_pipe1  <= s_pipe0;
        ct_pipe0 <= ct_mem[ct_addr];
        ct_pipe1 <= ct_pipe0;
    end
    assign s_rddata  = s_pipe1;
    assign ct_rddata = ct_pipe1;

    always @(negedge clk) begin
        if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
            pt_cnt          <= pt_cnt + 1;
            if (pt_addr == 8'd1) begin
                snap1 <= s_mem[1];
                snap2 <= s_mem[2];
                snap3 <= s_mem[3];
            end
        end
        if (s_wren || pt_wren) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_s();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic set_ksa(input logic [23:0] key);
        byte_t kb [3];
        byte_t kj;
        byte_t t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        set_identity();
        kj = 8'h00;
        for (int a = 0; a < 256; a++) begin
            kj        = kj + s_init[a] + kb[a % 3];
            t         = s_init[a];
            s_init[a] = s_init[kj];
            s_init[kj] = t;
        end
    endtask

    task automatic model(input int n);
        byte_t m [256];
        byte_t mi, mj, t, fi;
        for (int a = 0; a < 256; a++) m[a] = s_init[a];
        mi = 8'h00;
        mj = 8'h00;
        for (int b = 0; b < n; b++) begin
            mi     = mi + 8'h01;
            mj     = mj + m[mi];
            t      = m[mi];
            m[mi]  = m[mj];
            m[mj]  = t;
            fi     = m[mi] + m[mj];
            exp_pt[b] = m[fi] ^ ct_mem[b];
        end
    endtask

    task automatic run(input int drop_after, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (!done_flag && cyc < 1000) begin
            if (cyc == drop_after) start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int base;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        set_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", {8'h00, s_addr, ct_addr, pt_addr}, 32'h0);
        chk("rst_data", {16'h0, s_wrdata, pt_wrdata}, 32'h0);
        chk("rst_flags", {28'h0, s_wren, pt_wren, done_flag, key_bad}, 32'h0);
        load_s();
        rst_n = 1'b1;

        base = wr_cnt;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_wr", wr_cnt - base, 0);
        chk("idle_done", {31'h0, done_flag}, 32'h0);

`ifdef RC4_ASCII_CHECK_EN
        ct_mem[0] = 8'h63;
        base = pt_cnt;
        run(-1, cyc);
        chk("asc_cyc", cyc, 31);
        chk("asc_bad", {31'h0, key_bad}, 32'h1);
        chk("asc_done", {31'h0, done_flag}, 32'h1);
        chk("asc_pt0", {24'h0, pt_mem[0]}, 32'h61);
        chk("asc_pt1", {24'h0, pt_mem[1]}, 32'h05);
        repeat (40) @(posedge clk);
        #1;
        chk("asc_cnt", pt_cnt - base, 2);
        chk("asc_hold", {30'h0, key_bad, done_flag}, 32'h3);
`else
        // Identity S: hand-derived first two bytes and the byte-1 swap.
        base = pt_cnt;
        run(-1, cyc);
        chk("id_pt0", {24'h0, pt_mem[0]}, 32'h02);
        chk("id_pt1", {24'h0, pt_mem[1]}, 32'h05);
        chk("id_s1", {24'h0, snap1}, 32'h01);
        chk("id_s2", {24'h0, snap2}, 32'h03);
        chk("id_s3", {24'h0, snap3}, 32'h02);
        chk("id_cnt", pt_cnt - base, MSG_LEN);
        chk("id_cyc", cyc, MSG_LEN * 15 + 1);
        model(MSG_LEN);
        for (int b = 2; b < MSG_LEN; b++) chk($sformatf("id_pt%0d", b), {24'h0, pt_mem[b]}, {24'h0, exp_pt[b]});
        chk("id_keybad", {31'h0, key_bad}, 32'h0);

        start = 1'b1;
        base  = wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_hold", {31'h0, done_flag}, 32'h1);
        chk("done_wr", wr_cnt - base, 0);
        chk("done_addr", {8'h00, s_addr, ct_addr, pt_addr}, 32'h0);

        // "Key" test vector, start dropped mid-run.
        do_reset();
        set_ksa(24'h4B6579);
        for (int b = 0; b < 9; b++) ct_mem[b] = key_ct[b];
        load_s();
        rst_n = 1'b1;
        base  = pt_cnt;
        run(5, cyc);
        for (int b = 0; b < 9; b++) chk($sformatf("key_pt%0d", b), {24'h0, pt_mem[b]}, {24'h0, plain_txt[b]});
        chk("key_cnt", pt_cnt - base, 9);
        chk("key_cyc", cyc, 9 * 15 + 1);

        // Reset asserted in WAIT_J of byte 3 (offset 3*15+5 after start).
        do_reset();
        load_s();
        rst_n = 1'b1;
        base  = pt_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (50) @(posedge clk);
        #1;
        chk("mid_cnt", pt_cnt - base, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_addr", {8'h00, s_addr, ct_addr, pt_addr}, 32'h0);
        chk("mid_data", {16'h0, s_wrdata, pt_wrdata}, 32'h0);
        chk("mid_flags", {28'h0, s_wren, pt_wren, done_flag, key_bad}, 32'h0);
        start = 1'b0;
        @(posedge clk);
        #1;
        load_s();
        rst_n = 1'b1;
        for (int b = 0; b < 9; b++) pt_mem[b] = 8'h00;
        base = pt_cnt;
        run(-1, cyc);
        for (int b = 0; b < 9; b++) chk($sformatf("rerun_pt%0d", b), {24'h0, pt_mem[b]}, {24'h0, plain_txt[b]});
        chk("rerun_cnt", pt_cnt - base, 9);

        // Crafted S: byte 1 sees i == j == 2.
        do_reset();
        set_identity();
        s_init[1]   = 8'hFF;
        s_init[255] = 8'h01;
        s_init[2]   = 8'h03;
        s_init[3]   = 8'h02;
        for (int b = 0; b < 256; b++) ct_mem[b] = 8'h00;
        load_s();
        rst_n = 1'b1;
        base  = pt_cnt;
        run(-1, cyc);
        model(MSG_LEN);
        for (int b = 0; b < MSG_LEN; b++) chk($sformatf("eq_pt%0d", b), {24'h0, pt_mem[b]}, {24'h0, exp_pt[b]});
        chk("eq_pt1_hand", {24'h0, pt_mem[1]}, 32'h06);
        chk("eq_s2", {24'h0, snap2}, 32'h03);
        chk("eq_s1", {24'h0, snap1}, 32'h01);
        chk("eq_cnt", pt_cnt - base, MSG_LEN);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Third RC4 stage. Runs the pseudo-random generation algorithm (PRGA) over the S array that the key-scheduling stage has already permuted in the shared 256x8 S RAM.
- For each ciphertext byte it produces one keystream byte, XORs it with the ciphertext ROM byte, and writes the result to the plaintext RAM.
- Starts when the upstream KSA stage raises its done flag. Owns the S RAM port for its whole run.

Parameters:
- MSG_LEN, 32, number of ciphertext bytes processed (1..256).
- RD_LAT, 2, synchronous read latency in cycles of both the S RAM and the ciphertext ROM.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  KSA done flag; level-sensitive, sampled in IDLE only
- done_flag  output  1  high once all bytes are written (or early abort); held until reset
- s_addr  output  8  S RAM address
- s_rddata  input  8  S RAM read data, valid RD_LAT cycles after address
- s_wrdata  output  8  S RAM write data
- s_wren  output  1  S RAM write enable
- ct_addr  output  8  ciphertext ROM address
- ct_rddata  input  8  ciphertext ROM data, RD_LAT latency
- pt_addr  output  8  plaintext RAM address
- pt_wrdata  output  8  plaintext RAM write data
- pt_wren  output  1  plaintext RAM write enable
- key_bad  output  1  invalid-plaintext flag (see Optional Feature)

Behaviour:
- Reset (async, any state, including mid-run): state=IDLE; i, j, k=0; all addresses and write data=0; s_wren, pt_wren, done_flag, key_bad=0.
- Arithmetic: i, j, f-address are 8-bit and wrap mod 256. k counts 0..MSG_LEN-1.
- IDLE: when start=1, go to RD_I with i=1 (i is pre-incremented), j=0, k=0.
- A read is three phases: RD_x (drive address, wren=0, 1 cycle), WAIT_x (RD_LAT cycles), SAVE_x (capture data, 1 cycle). Total RD_LAT+2 cycles.
- RD_I/WAIT_I/SAVE_I: s_addr=i; capture si; compute j <= j+si.
- RD_J/WAIT_J/SAVE_J: s_addr=j; capture sj.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_J: s_addr=j, s_wrdata=si, s_wren=1.
  - If i==j, the final S[i]=si, which is the correct swap result. No special case.
- RD_F/WAIT_F/SAVE_F: s_addr=si+sj and ct_addr=k, issued in the same cycle; capture f and ct.
- WR_PT: pt_addr=k, pt_wrdata=f^ct, pt_wren=1 for exactly one cycle.
  - If k==MSG_LEN-1, go to DONE.
  - Otherwise k++, i++, go to RD_I.
- Per-byte cost: 3*(RD_LAT+2)+3 cycles (15 at RD_LAT=2). No overlap between bytes.
- DONE: done_flag=1, all wren=0, addresses=0. Stay in DONE until reset; start is ignored.
- start falling mid-run is ignored; the run completes.
- Write enables are low in every state except WR_I, WR_J, WR_PT.

Optional Feature:
- Macro: RC4_ASCII_CHECK_EN.
- Defined:
  - In WR_PT, if pt_wrdata is not in 8'h61..8'h7A and not 8'h20, set key_bad=1.
  - The byte is still written. Go directly to DONE (early abort).
  - key_bad holds until reset.
- Undefined: key_bad tied 0; all MSG_LEN bytes are always processed.

Decomposition:
- rc4_pkg holds:
  - typedef byte_t (logic [7:0]);
  - state enum prga_state_t (IDLE, RD_I, WAIT_I, SAVE_I, RD_J, WAIT_J, SAVE_J, WR_I, WR_J, RD_F, WAIT_F, SAVE_F, WR_PT, DONE);
  - constants S_SIZE=256 and ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SP=8'h20.
- One sub-module: rc4_ascii_chk, combinational byte-validity check, instantiated only under RC4_ASCII_CHECK_EN.
- Wait-cycle counter is local to rc4_prga_decrypt.

Test Plan:
- Identity S (S[x]=x), ct all 8'h00, MSG_LEN=2 -> pt[0]=8'h02, pt[1]=8'h05; after run S[2]=8'h03, S[3]=8'h02.
- Bench loads S via a KSA model with key 24'h4B6579 ("Key"), ct=BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9 -> pt="Plaintext" (50 6C 61 69 6E 74 65 78 74); done_flag rises exactly 9*15+1 cycles after start sampled.
- start held low 100 cycles -> no wren pulses; done_flag=0. Then start=1 -> run proceeds normally.
- Assert rst_n low during WAIT_J of byte 3 -> all outputs 0 immediately. Re-run with start=1 -> results identical to a clean run on a reloaded S.
- With RC4_ASCII_CHECK_EN, identity S, ct=8'h61^keystream for byte0, 8'h00 for byte1 -> pt[0]=8'h61 accepted; pt[1]=8'h05 flags key_bad=1; done_flag=1; no pt write for k>=2.
- Construct S so i==j occurs (S[1]=8'hFF, j starts 0 -> j=8'hFF; force i==j case via a bench-crafted S) -> S contents unchanged at that index; keystream matches the bench model.
